// File: rtl/uart_mmio_peripheral_if.sv
// Data-memory bus seen by the UART peripheral: address, store data/width, load strobe,
// plus the combinational select and read data returned to the core's load mux.
interface uart_mmio_peripheral_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mem_write;
    logic        mem_read;
    logic        sel;
    logic [31:0] rdata;

    modport master (output addr, wdata, mem_write, mem_read, input sel, rdata);
    modport slave  (input addr, wdata, mem_write, mem_read, output sel, rdata);
endinterface

// File: rtl/uart_mmio_peripheral.sv
// Memory-mapped 8N1 UART: TX FIFO, RX holding register, status register.
// Receiver is built only when UART_RX_EN is defined; otherwise RX reads as idle.
module uart_mmio_peripheral #(
    parameter int          CLKS_PER_BIT  = 868,
    parameter int          TX_FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0400
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_mmio_peripheral_if.slave  bus,
    output logic                   uart_tx,
    input  logic                   uart_rx,
    output logic                   tx_full,
    output logic                   rx_valid
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [1:0] offset;
    logic       wr_en, tx_push, stat_wr, rx_pop, push_ok, tx_pop, tx_empty, tx_busy;
    logic       tx_overflow, rx_overrun;
    logic [7:0] rx_hold;

    assign offset  = bus.addr[3:2];
    assign bus.sel = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en   = bus.sel && (bus.mem_write != 2'b00);
    assign tx_push = wr_en && (offset == 2'd0);
    assign stat_wr = wr_en && (offset == 2'd2);
    assign rx_pop  = bus.sel && bus.mem_read && (offset == 2'd1) && rx_valid;

    logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;

    assign tx_full  = (fifo_count == (AW+1)'(TX_FIFO_DEPTH));
    assign tx_empty = (fifo_count == '0);
    assign push_ok  = tx_push && !tx_full;

    // Fullness is judged before the edge, so a simultaneous pop never rescues a push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, tx_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (stat_wr)               tx_overflow <= 1'b0;
            else if (tx_push && tx_full) tx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus.wdata[7:0];
    end

    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;

    assign tx_busy = (tx_state != TX_IDLE);

    // uart_tx is a registered copy of the current bit, giving the two-cycle write-to-start latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            case (tx_state)
                TX_START: uart_tx <= 1'b0;
                TX_DATA:  uart_tx <= tx_shift[0];
                default:  uart_tx <= 1'b1;
            endcase
        end
    end

    always_comb begin
        tx_next    = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = fifo_mem[rd_ptr];
                    tx_cnt_n   = '0;
                    tx_next    = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    tx_bit_n = '0;
                    tx_next  = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 3'd7) tx_next = TX_STOP;
                    else                tx_bit_n = tx_bit + 3'd1;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = fifo_mem[rd_ptr];
                        tx_next    = TX_START;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

`ifdef UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state, rx_next;
    logic [1:0]    rx_sync;
    logic          rx_s, rx_prev, rx_done;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;

    assign rx_s = rx_sync[1];

    // A byte completing while one is unread is dropped unless that byte is popped this same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync    <= 2'b11;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_hold    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rx};
            rx_prev  <= rx_s;
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            if (rx_done && (!rx_valid || rx_pop)) begin
                rx_hold  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end
            if (stat_wr)                           rx_overrun <= 1'b0;
            else if (rx_done && rx_valid && !rx_pop) rx_overrun <= 1'b1;
        end
    end

    always_comb begin
        rx_next    = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_cnt_n = '0;
                    rx_next  = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == BIT_HALF) begin
                    rx_cnt_n = '0;
                    rx_bit_n = '0;
                    rx_next  = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_next = RX_STOP;
                    else                rx_bit_n = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n = '0;
                    rx_done  = rx_s;
                    rx_next  = RX_IDLE;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0]};
`else
    assign rx_valid   = 1'b0;
    assign rx_hold    = 8'h00;
    assign rx_overrun = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{bus.wdata[31:8], bus.addr[1:0], uart_rx, rx_pop};
`endif

    always_comb begin
        bus.rdata = '0;
        case (offset)
            2'd1:    bus.rdata = {24'b0, rx_valid ? rx_hold : 8'h00};
            2'd2:    bus.rdata = {26'b0, rx_overrun, tx_overflow, tx_busy, rx_valid, tx_empty, tx_full};
            default: bus.rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_uart_mmio_peripheral.sv
// Scoreboard bench for uart_mmio_peripheral: reads and decoded TX frames are checked
// against queues of hand-computed expectations. Works with or without UART_RX_EN.
module tb_uart_mmio_peripheral;
    localparam int CPB = 4;
`ifdef UART_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, uart_tx, uart_rx, tx_full, rx_valid;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [31:0] rd_exp[$];
    logic [7:0]  tx_exp[$];
    int          fall_cyc[$];

    uart_mmio_peripheral_if bus();

    uart_mmio_peripheral #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(4), .BASE_ADDR(32'h400)) dut (
        .clk(clk), .reset(reset), .bus(bus), .uart_tx(uart_tx),
        .uart_rx(uart_rx), .tx_full(tx_full), .rx_valid(rx_valid));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        bus.addr = a; bus.wdata = d; bus.mem_write = w;
        @(posedge clk); #1;
        bus.mem_write = 2'b00;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp);
        rd_exp.push_back(exp);
        bus.addr = a; bus.mem_read = 1'b1;
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_drain(input int budget);
        for (int i = 0; i < budget && tx_exp.size() != 0; i++) idle(1);
        checks++;
        if (tx_exp.size() != 0) begin
            errors++;
            $display("[TB] FAIL tx_drain: %0d frames outstanding, required 0", tx_exp.size());
        end
    endtask

    task automatic rx_bit(input logic v);
        uart_rx = v;
        idle(CPB);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_v);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop_v);
        if (!stop_v) rx_bit(1'b1);
    endtask

    // Read monitor: every selected load is matched with the oldest expected value.
    always @(negedge clk) begin
        if (!reset && bus.mem_read && bus.sel) begin
            if (rd_exp.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL read@%0h: got 0x%08h with no expected value", bus.addr, bus.rdata);
            end else begin
                check_output($sformatf("read@%0h", bus.addr), bus.rdata, rd_exp.pop_front());
            end
        end
    end

    // TX monitor: decode frames at mid-bit and compare against the expected byte queue.
    initial begin : tx_mon
        logic [7:0] b;
        bit aborted;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                fall_cyc.push_back(cyc);
                b = 8'h00;
                aborted = 1'b0;
                for (int m = 1; m <= 38 && !aborted; m++) begin
                    @(negedge clk);
                    if (reset) aborted = 1'b1;
                    else if (m == 2) check_output("tx_start_bit", uart_tx, 0);
                    else if (m >= 6 && m <= 34 && (m - 2) % 4 == 0) b[(m - 2) / 4 - 1] = uart_tx;
                    else if (m == 38) begin
                        check_output("tx_stop_bit", uart_tx, 1);
                        if (tx_exp.size() == 0) begin
                            checks++; errors++;
                            $display("[TB] FAIL tx_byte: got 0x%02h with no frame expected", b);
                        end else begin
                            check_output("tx_byte", b, tx_exp.pop_front());
                        end
                    end
                end
                if (aborted) tx_exp.delete();
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int fc;
        reset = 1'b1; uart_rx = 1'b1;
        bus.addr = '0; bus.wdata = '0; bus.mem_write = 2'b00; bus.mem_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_uart_tx", uart_tx, 1);
        check_output("reset_tx_full", tx_full, 0);
        check_output("reset_rx_valid", rx_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        bus_read(32'h408, 32'h02);

        $display("[TB] single SB frame");
        tx_exp.push_back(8'hA5);
        apply_stimulus(32'h400, 32'hFFFF_FFA5, 2'b01);
        check_output("tx_line_e0", uart_tx, 1);
        idle(1);
        check_output("tx_line_e1", uart_tx, 1);
        idle(1);
        check_output("tx_fall_e2", uart_tx, 0);
        idle(38);
        bus_read(32'h408, 32'h0A);
        bus_read(32'h408, 32'h02);
        wait_tx_drain(20);

        $display("[TB] FIFO fill and overflow");
        fc = fall_cyc.size();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) tx_exp.push_back(8'(i));
            apply_stimulus(32'h400, 32'h100 + i, 2'b11);
            if (i == 4) check_output("tx_full_after4", tx_full, 0);
            if (i == 5) check_output("tx_full_after5", tx_full, 1);
        end
        bus_read(32'h408, 32'h19);
        wait_tx_drain(300);
        check_output("burst_frames", fall_cyc.size() - fc, 5);
        for (int k = fc + 1; k < fall_cyc.size(); k++)
            check_output("burst_gap", fall_cyc[k] - fall_cyc[k-1], 40);
        idle(4);
        bus_read(32'h408, 32'h12);
        apply_stimulus(32'h408, 32'h0, 2'b11);
        bus_read(32'h408, 32'h02);

        $display("[TB] decode and store widths");
        bus.addr = 32'h410; #1;
        check_output("sel_outside", bus.sel, 0);
        bus.addr = 32'h40C; #1;
        check_output("sel_inside", bus.sel, 1);
        fc = fall_cyc.size();
        apply_stimulus(32'h414, 32'h99, 2'b01);
        apply_stimulus(32'h40C, 32'hFF, 2'b11);
        bus_read(32'h40C, 32'h0);
        bus_read(32'h400, 32'h0);
        idle(20);
        check_output("no_frame_ignored_writes", fall_cyc.size() - fc, 0);
        tx_exp.push_back(8'h34);
        apply_stimulus(32'h400, 32'hBEEF_1234, 2'b10);
        wait_tx_drain(60);

        $display("[TB] RX single frame");
        rx_frame(8'h3C, 1'b1);
        idle(4);
        check_output("rx_valid_3c", rx_valid, RX_EN ? 1 : 0);
        bus_read(32'h408, RX_EN ? 32'h06 : 32'h02);
        bus_read(32'h404, RX_EN ? 32'h3C : 32'h0);
        check_output("rx_valid_after_pop", rx_valid, 0);
        bus_read(32'h404, 32'h0);

        $display("[TB] RX overrun");
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        idle(4);
        bus_read(32'h408, RX_EN ? 32'h26 : 32'h02);
        bus_read(32'h404, RX_EN ? 32'h11 : 32'h0);
        bus_read(32'h408, RX_EN ? 32'h22 : 32'h02);
        apply_stimulus(32'h408, 32'h0, 2'b11);
        bus_read(32'h408, 32'h02);

        $display("[TB] RX glitch and framing error");
        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(20);
        check_output("rx_after_glitch", rx_valid, 0);
        rx_frame(8'h55, 1'b0);
        idle(4);
        check_output("rx_after_framing", rx_valid, 0);
        bus_read(32'h408, 32'h02);
        rx_frame(8'h5A, 1'b1);
        idle(4);
        check_output("rx_valid_5a", rx_valid, RX_EN ? 1 : 0);
        bus_read(32'h404, RX_EN ? 32'h5A : 32'h0);

        $display("[TB] reset mid-frame");
        fc = fall_cyc.size();
        apply_stimulus(32'h400, 32'h00, 2'b01);
        idle(14);
        check_output("tx_mid_data", uart_tx, 0);
        reset = 1'b1;
        #1;
        check_output("tx_reset_async", uart_tx, 1);
        idle(2);
        reset = 1'b0;
        idle(60);
        check_output("no_tx_after_reset", fall_cyc.size() - fc, 1);
        check_output("tx_full_after_reset", tx_full, 0);
        check_output("rx_valid_after_reset", rx_valid, 0);
        bus_read(32'h408, 32'h02);
        check_output("reads_consumed", rd_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
